mem_arbiter: RTL and testbench

Shares the single tagged main-memory port between the instruction-side (ime) and data-side (dme) cache refill paths. Round-robin arbitration is applied to request issue. A table of memory-assigned IDs records which client owns each in-flight transaction, so out-of-order responses are routed back to the right client. Sits between the two cache miss engines and the memory controller. On the client side it presents the same enable / in_use / ID / ack handshake that the caches already speak.

---
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one tagged memory port between the I and D refill paths,
// routing out-of-order responses back to their owner through an ID ownership table.
package const_pkg;
  localparam int ID_WIDTH = 3;
  localparam int PA_WIDTH = 32;
  localparam int LINE_WIDTH = 64;
endpackage

module mem_arbiter #(
  parameter int ID_WIDTH = const_pkg::ID_WIDTH,
  parameter int PA_WIDTH = const_pkg::PA_WIDTH,
  parameter int LINE_WIDTH = const_pkg::LINE_WIDTH,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ic_req,
  input  logic                  i_dc_req,
  input  logic [PA_WIDTH-1:0]   i_ic_addr,
  input  logic [PA_WIDTH-1:0]   i_dc_addr,
  output logic                  o_ic_in_use,
  output logic                  o_dc_in_use,
  output logic [ID_WIDTH-1:0]   o_ic_id_request,
  output logic [ID_WIDTH-1:0]   o_dc_id_request,
  output logic                  o_ic_resp_enable,
  output logic                  o_dc_resp_enable,
  output logic [LINE_WIDTH-1:0] o_ic_resp_data,
  output logic [LINE_WIDTH-1:0] o_dc_resp_data,
  output logic [ID_WIDTH-1:0]   o_ic_resp_id,
  output logic [ID_WIDTH-1:0]   o_dc_resp_id,
  input  logic                  i_ic_ack,
  input  logic                  i_dc_ack,
  output logic                  o_mem_enable,
  output logic [PA_WIDTH-1:0]   o_mem_addr,
  output logic                  o_mem_ack,
  input  logic                  i_mem_in_use,
  input  logic [ID_WIDTH-1:0]   i_mem_id_request,
  input  logic                  i_mem_enable,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic [ID_WIDTH-1:0]   i_mem_id_response,
  output logic [7:0]            o_orphan_count
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int NE = 1 << ID_WIDTH;
  logic [CW-1:0] ic_cnt, dc_cnt;
  logic last_d;
  logic [NE-1:0] tab_v, tab_d;
  logic ic_elig, dc_elig, ic_grant, dc_grant, accept, hit, orphan, ic_done, dc_done;
  assign ic_elig = i_ic_req & (ic_cnt < CW'(MAX_OUT));
  assign dc_elig = i_dc_req & (dc_cnt < CW'(MAX_OUT));
  // Gating with rst forces every combinational output idle while reset is held.
  assign ic_grant = rst & ic_elig & (~dc_elig | last_d);
  assign dc_grant = rst & dc_elig & (~ic_elig | ~last_d);
  assign accept = (ic_grant | dc_grant) & ~i_mem_in_use;
  assign o_mem_enable = ic_grant | dc_grant;
  assign o_mem_addr = ic_grant ? i_ic_addr : dc_grant ? i_dc_addr : '0;
  assign o_ic_in_use = ~(ic_grant & ~i_mem_in_use);
  assign o_dc_in_use = ~(dc_grant & ~i_mem_in_use);
  assign o_ic_id_request = rst ? i_mem_id_request : '0;
  assign o_dc_id_request = rst ? i_mem_id_request : '0;
  assign hit = rst & i_mem_enable & tab_v[i_mem_id_response];
  assign orphan = rst & i_mem_enable & ~tab_v[i_mem_id_response];
  assign o_ic_resp_enable = hit & ~tab_d[i_mem_id_response];
  assign o_dc_resp_enable = hit & tab_d[i_mem_id_response];
  assign o_ic_resp_data = o_ic_resp_enable ? i_mem_data : '0;
  assign o_dc_resp_data = o_dc_resp_enable ? i_mem_data : '0;
  assign o_ic_resp_id = o_ic_resp_enable ? i_mem_id_response : '0;
  assign o_dc_resp_id = o_dc_resp_enable ? i_mem_id_response : '0;
  assign ic_done = o_ic_resp_enable & i_ic_ack;
  assign dc_done = o_dc_resp_enable & i_dc_ack;
  assign o_mem_ack = ic_done | dc_done | orphan;
  // Allocation is written after the free so a same-cycle reuse of an ID keeps the new owner.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ic_cnt <= '0;
      dc_cnt <= '0;
      last_d <= 1'b1;
      tab_v <= '0;
      tab_d <= '0;
      o_orphan_count <= '0;
    end else begin
      ic_cnt <= ic_cnt + CW'(accept & ic_grant) - CW'(ic_done);
      dc_cnt <= dc_cnt + CW'(accept & dc_grant) - CW'(dc_done);
      if (accept) last_d <= dc_grant;
      if (ic_done | dc_done) tab_v[i_mem_id_response] <= 1'b0;
      if (accept) begin
        tab_v[i_mem_id_request] <= 1'b1;
        tab_d[i_mem_id_request] <= dc_grant;
      end
      if (orphan && o_orphan_count != 8'hFF) o_orphan_count <= o_orphan_count + 8'd1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus checked against an ownership/count model of the arbiter.
module tb_mem_arbiter;
  localparam int IW = const_pkg::ID_WIDTH;
  localparam int PW = const_pkg::PA_WIDTH;
  localparam int LW = const_pkg::LINE_WIDTH;
  localparam int MO = 2;
  localparam int NE = 1 << IW;
  logic clk = 0, rst = 0;
  logic i_ic_req, i_dc_req, i_ic_ack, i_dc_ack, i_mem_in_use, i_mem_enable;
  logic [PW-1:0] i_ic_addr, i_dc_addr, o_mem_addr;
  logic [IW-1:0] i_mem_id_request, i_mem_id_response;
  logic [IW-1:0] o_ic_id_request, o_dc_id_request, o_ic_resp_id, o_dc_resp_id;
  logic [LW-1:0] i_mem_data, o_ic_resp_data, o_dc_resp_data;
  logic o_ic_in_use, o_dc_in_use, o_ic_resp_enable, o_dc_resp_enable, o_mem_enable, o_mem_ack;
  logic [7:0] o_orphan_count;
  int n_chk = 0, n_fail = 0;
  int m_cnt[2];
  int m_last;
  bit m_val[NE];
  int m_own[NE];
  int m_orph;
  always #5 clk = ~clk;
  mem_arbiter #(.MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .i_ic_req(i_ic_req), .i_dc_req(i_dc_req), .i_ic_addr(i_ic_addr), .i_dc_addr(i_dc_addr),
    .o_ic_in_use(o_ic_in_use), .o_dc_in_use(o_dc_in_use),
    .o_ic_id_request(o_ic_id_request), .o_dc_id_request(o_dc_id_request),
    .o_ic_resp_enable(o_ic_resp_enable), .o_dc_resp_enable(o_dc_resp_enable),
    .o_ic_resp_data(o_ic_resp_data), .o_dc_resp_data(o_dc_resp_data),
    .o_ic_resp_id(o_ic_resp_id), .o_dc_resp_id(o_dc_resp_id),
    .i_ic_ack(i_ic_ack), .i_dc_ack(i_dc_ack),
    .o_mem_enable(o_mem_enable), .o_mem_addr(o_mem_addr), .o_mem_ack(o_mem_ack),
    .i_mem_in_use(i_mem_in_use), .i_mem_id_request(i_mem_id_request),
    .i_mem_enable(i_mem_enable), .i_mem_data(i_mem_data), .i_mem_id_response(i_mem_id_response),
    .o_orphan_count(o_orphan_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, got, exp);
      $error("check %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_last = 1;
    m_orph = 0;
    for (int k = 0; k < NE; k++) m_val[k] = 0;
  endtask
  task automatic idle();
    i_ic_req = 0; i_dc_req = 0; i_ic_ack = 0; i_dc_ack = 0;
    i_mem_in_use = 0; i_mem_enable = 0;
    i_ic_addr = '0; i_dc_addr = '0; i_mem_id_request = '0; i_mem_id_response = '0; i_mem_data = '0;
  endtask
  task automatic step();
    int g, o;
    bit ei, ed, ack;
    logic [PW-1:0] ea;
    #1;
    ei = i_ic_req && m_cnt[0] < MO;
    ed = i_dc_req && m_cnt[1] < MO;
    if (ei && ed) g = m_last == 1 ? 0 : 1;
    else if (ei) g = 0;
    else if (ed) g = 1;
    else g = -1;
    ea = g == 0 ? i_ic_addr : g == 1 ? i_dc_addr : '0;
    o = (i_mem_enable && m_val[i_mem_id_response]) ? m_own[i_mem_id_response] : -1;
    ack = o == 0 ? i_ic_ack : o == 1 ? i_dc_ack : i_mem_enable;
    chk("mem_enable", o_mem_enable, g >= 0);
    chk("mem_addr", o_mem_addr, ea);
    chk("ic_in_use", o_ic_in_use, !(g == 0 && !i_mem_in_use));
    chk("dc_in_use", o_dc_in_use, !(g == 1 && !i_mem_in_use));
    chk("id_request", {o_ic_id_request, o_dc_id_request}, {i_mem_id_request, i_mem_id_request});
    chk("ic_resp_enable", o_ic_resp_enable, o == 0);
    chk("dc_resp_enable", o_dc_resp_enable, o == 1);
    chk("ic_resp_data", o_ic_resp_data, o == 0 ? i_mem_data : '0);
    chk("dc_resp_data", o_dc_resp_data, o == 1 ? i_mem_data : '0);
    chk("resp_ids", {o_ic_resp_id, o_dc_resp_id},
        {o == 0 ? i_mem_id_response : IW'(0), o == 1 ? i_mem_id_response : IW'(0)});
    chk("mem_ack", o_mem_ack, ack);
    if (o >= 0 && ack) begin
      m_val[i_mem_id_response] = 0;
      m_cnt[o]--;
    end
    if (g >= 0 && !i_mem_in_use) begin
      m_val[i_mem_id_request] = 1;
      m_own[i_mem_id_request] = g;
      m_cnt[g]++;
      m_last = g;
    end
    if (o < 0 && i_mem_enable && m_orph < 255) m_orph++;
    @(posedge clk);
    #1;
    chk("orphan_count", o_orphan_count, m_orph);
  endtask
  task automatic drain();
    for (int k = 0; k < NE; k++)
      if (m_val[k]) begin
        idle();
        i_mem_enable = 1; i_mem_id_response = IW'(k); i_ic_ack = 1; i_dc_ack = 1;
        step();
      end
    idle();
  endtask
  task automatic rst_check();
    i_ic_req = 1; i_dc_req = 1; i_ic_addr = 32'h1234; i_dc_addr = 32'h5678;
    i_mem_enable = 1; i_mem_id_response = 3'd2; i_mem_id_request = 3'd5;
    i_mem_data = 64'hDEAD; i_ic_ack = 1; i_dc_ack = 1;
    #1;
    chk("rst_mem_enable", o_mem_enable, 1'b0);
    chk("rst_mem_addr", o_mem_addr, '0);
    chk("rst_mem_ack", o_mem_ack, 1'b0);
    chk("rst_in_use", {o_ic_in_use, o_dc_in_use}, 2'b11);
    chk("rst_resp_enable", {o_ic_resp_enable, o_dc_resp_enable}, 2'b00);
    chk("rst_ids", {o_ic_id_request, o_dc_id_request, o_ic_resp_id, o_dc_resp_id}, '0);
    chk("rst_data", o_ic_resp_data | o_dc_resp_data, '0);
    chk("rst_orphan", o_orphan_count, 8'd0);
    m_reset();
    @(negedge clk);
    rst = 1;
    idle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] seq, exp_seq;
    int pid;
    idle();
    #12;
    rst_check();
    // single I request, routed response
    i_ic_req = 1; i_ic_addr = 32'h1000; i_mem_id_request = 3'd3;
    step();
    idle(); step();
    i_mem_enable = 1; i_mem_id_response = 3'd3; i_mem_data = 64'hA5A5A5A5A5A5A5A5;
    step();
    i_ic_ack = 1;
    step();
    idle(); step();
    // fairness with a busy stretch in the middle
    seq = '0;
    exp_seq = m_last == 1 ? 6'b010101 : 6'b101010;
    pid = -1;
    for (int k = 0; k < 9; k++) begin
      idle();
      i_ic_req = 1; i_dc_req = 1; i_ic_addr = 32'h100 + k; i_dc_addr = 32'h200 + k;
      i_mem_in_use = (k >= 3 && k < 6);
      i_mem_id_request = IW'(k);
      if (pid >= 0 && m_val[pid]) begin
        i_mem_enable = 1; i_mem_id_response = IW'(pid); i_ic_ack = 1; i_dc_ack = 1;
      end
      #1;
      if (!o_ic_in_use) seq = {seq[4:0], 1'b0};
      else if (!o_dc_in_use) seq = {seq[4:0], 1'b1};
      if (!i_mem_in_use) pid = k;
      step();
    end
    chk("rr_order", seq, exp_seq);
    drain();
    // per-client outstanding limit
    i_ic_req = 1; i_mem_id_request = 3'd1; step();
    i_mem_id_request = 3'd2; step();
    i_dc_req = 1; i_dc_addr = 32'h3000; i_mem_id_request = 3'd3;
    #1;
    chk("limit_ic_in_use", o_ic_in_use, 1'b1);
    chk("limit_dc_granted", o_dc_in_use, 1'b0);
    step();
    i_dc_req = 0; i_mem_id_request = 3'd4;
    i_mem_enable = 1; i_mem_id_response = 3'd1; i_ic_ack = 1;
    step();
    idle(); i_ic_req = 1; i_mem_id_request = 3'd5;
    #1;
    chk("limit_regrant", o_ic_in_use, 1'b0);
    step();
    drain();
    // out-of-order responses
    i_ic_req = 1; i_mem_id_request = 3'd5; step();
    idle(); i_dc_req = 1; i_mem_id_request = 3'd6; step();
    idle(); i_mem_enable = 1; i_mem_id_response = 3'd6; i_mem_data = 64'h66; step();
    i_dc_ack = 1; step();
    i_dc_ack = 0; i_mem_id_response = 3'd5; i_mem_data = 64'h55; step();
    i_ic_ack = 1; step();
    drain();
    // orphans and saturation
    i_mem_enable = 1; i_mem_id_response = 3'd7; step();
    for (int k = 0; k < 300; k++) step();
    chk("orphan_saturated", o_orphan_count, 8'd255);
    idle();
    // same-cycle free and reuse of one ID
    i_ic_req = 1; i_mem_id_request = 3'd4; step();
    idle(); i_dc_req = 1; i_mem_id_request = 3'd4;
    i_mem_enable = 1; i_mem_id_response = 3'd4; i_ic_ack = 1; step();
    idle(); i_mem_enable = 1; i_mem_id_response = 3'd4; i_mem_data = 64'h44;
    #1;
    chk("reuse_to_dc", {o_ic_resp_enable, o_dc_resp_enable}, 2'b01);
    step();
    i_dc_ack = 1; step();
    drain();
    // random traffic
    for (int k = 0; k < 400; k++) begin
      i_ic_req = 1'($urandom_range(0, 1)); i_dc_req = 1'($urandom_range(0, 1));
      i_ic_addr = $urandom; i_dc_addr = $urandom;
      i_mem_in_use = ($urandom_range(0, 3) == 0);
      i_mem_id_request = IW'($urandom_range(0, NE - 1));
      i_mem_enable = 1'($urandom_range(0, 1));
      i_mem_id_response = IW'($urandom_range(0, NE - 1));
      i_mem_data = {$urandom, $urandom};
      i_ic_ack = 1'($urandom_range(0, 1)); i_dc_ack = 1'($urandom_range(0, 1));
      step();
    end
    drain();
    // reset with transactions in flight
    i_ic_req = 1; i_mem_id_request = 3'd2; step();
    idle(); i_dc_req = 1; i_mem_id_request = 3'd3; step();
    #2 rst = 0;
    rst_check();
    i_mem_enable = 1; i_mem_id_response = 3'd2; i_mem_data = 64'h22;
    step();
    chk("post_rst_orphan", o_orphan_count, 8'd1);
    idle(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
